// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and bus addresses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int UART_DATA_BITS = 8;

   // Store/load targets decoded by the memory subsystem.
   localparam logic [17:0] UART_TX_ADDR = 18'h20002;
   localparam logic [17:0] UART_RX_ADDR = 18'h20003;

   // Even parity: the XOR of all data bits.
   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with occupancy count; read data is the head entry, combinationally.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: a push while full is ignored (even with a simultaneous pop); a pop while empty is ignored.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: buffers CPU byte stores and shifts them out 8N1 LSB first (8E1 with UART_TX_PARITY_EN).
// Latency: a byte written into an empty FIFO while idle drives the start bit one edge after the write.
// Backpressure: none on the write strobe; writes while fifo_full are dropped and set sticky overflow.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clk_en,
   input  logic                          tx_wen,
   input  logic [UART_DATA_BITS-1:0]     tx_data,
   output logic                          tx,
   output logic                          tx_busy,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          tx_done_irq
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

   uart_state_t               state;
   uart_state_t               state_nxt;
   logic [15:0]               baud_cnt;
   logic [15:0]               baud_nxt;
   logic [2:0]                bit_idx;
   logic [2:0]                bit_nxt;
   logic [UART_DATA_BITS-1:0] shifter;
   logic [UART_DATA_BITS-1:0] shift_nxt;
   logic [UART_DATA_BITS-1:0] fifo_dat;
   logic                      fifo_empty;
   logic                      pop;
   logic                      push;
   logic                      push_ok;
   logic                      bit_end;
   logic                      done_nxt;
   logic                      tx_nxt;
   logic [CW-1:0]             count_nxt;
`ifdef UART_TX_PARITY_EN
   logic                      parity;
   logic                      parity_nxt;
`endif

   // Writes are sampled only on CPU-enabled cycles; serialization runs every cycle.
   assign push      = tx_wen && clk_en;
   assign push_ok   = push && !fifo_full;
   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign count_nxt = fifo_count + CW'(push_ok) - CW'(pop);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (tx_data),
      .pop       (pop),
      .pop_data  (fifo_dat),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Next-state logic: bit timing, shifting, and back-to-back frame loading from STOP.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shifter;
      pop       = 1'b0;
      done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_nxt = parity;
`endif
      if (state != IDLE) baud_nxt = bit_end ? 16'd0 : baud_cnt + 16'd1;
      case (state)
         IDLE:  pop = !fifo_empty;
         START: if (bit_end) state_nxt = DATA;
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  shift_nxt = shifter >> 1;
                  bit_nxt   = bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) state_nxt = STOP;
`endif
         STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Loading a new byte overrides everything above, from IDLE or at the end of STOP.
      if (pop) begin
         state_nxt = START;
         shift_nxt = fifo_dat;
         bit_nxt   = 3'd0;
         baud_nxt  = 16'd0;
`ifdef UART_TX_PARITY_EN
         parity_nxt = even_parity(fifo_dat);
`endif
      end
   end

   // Line level for the upcoming state, so tx is driven straight from a flop.
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_nxt = parity_nxt;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   // FSM and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shifter  <= '0;
`ifdef UART_TX_PARITY_EN
         parity   <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         shifter  <= shift_nxt;
`ifdef UART_TX_PARITY_EN
         parity   <= parity_nxt;
`endif
      end
   end

   // Registered status outputs; tx_busy tracks the state and count being loaded this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx          <= 1'b1;
         tx_busy     <= 1'b0;
         overflow    <= 1'b0;
         tx_done_irq <= 1'b0;
      end else begin
         tx          <= tx_nxt;
         tx_busy     <= (state_nxt != IDLE) || (count_nxt != '0);
         overflow    <= overflow | (push && fifo_full);
         tx_done_irq <= done_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: queue-based reference model predicts frames and status; a line monitor decodes tx.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_serializer;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clk_en = 1'b0;
   logic          tx_wen = 1'b0;
   logic [7:0]    tx_data = 8'h00;
   logic          tx;
   logic          tx_busy;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          tx_done_irq;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_frames = 0;
   int epoch    = 0;
   bit running  = 1'b1;

   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_en      (clk_en),
      .tx_wen      (tx_wen),
      .tx_data     (tx_data),
      .tx          (tx),
      .tx_busy     (tx_busy),
      .fifo_full   (fifo_full),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .tx_done_irq (tx_done_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a byte queue plus a frame countdown.
   typedef struct {
      logic [7:0] dat;
      int         start;
   } frame_t;

   logic [7:0] m_q[$];
   frame_t     exp_frames[$];
   int         m_rem = 0;
   bit         m_ovf = 1'b0;
   bit         m_irq = 1'b0;

   always @(posedge clk) begin
      bit     ended;
      bit     full_pre;
      frame_t f;
      cyc   = cyc + 1;
      m_irq = 1'b0;
      if (!rst_n) begin
         m_q.delete();
         exp_frames.delete();
         m_rem = 0;
         m_ovf = 1'b0;
         epoch++;
      end else begin
         full_pre = (m_q.size() == DEPTH);
         ended    = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            ended = (m_rem == 0);
         end
         if (m_rem == 0 && m_q.size() > 0) begin
            f.dat   = m_q.pop_front();
            f.start = cyc;
            exp_frames.push_back(f);
            m_rem = FRAME;
         end else if (ended) begin
            m_irq = 1'b1;
         end
         if (tx_wen && clk_en) begin
            if (full_pre) m_ovf = 1'b1;
            else          m_q.push_back(tx_data);
         end
      end
   end

   // Status outputs against the model every cycle.
   always @(negedge clk) begin
      if (running) begin
         check("fifo_count",  int'(fifo_count),  m_q.size());
         check("fifo_full",   int'(fifo_full),   int'(m_q.size() == DEPTH));
         check("tx_busy",     int'(tx_busy),     int'(m_rem > 0 || m_q.size() > 0));
         check("overflow",    int'(overflow),    int'(m_ovf));
         check("tx_done_irq", int'(tx_done_irq), int'(m_irq));
      end
   end

   // Line monitor: decodes each frame mid-bit and pops the scoreboard.
   initial begin : monitor
      forever begin
         int               st;
         int               ep;
         bit               aborted;
         logic [NBITS-1:0] bits;
         frame_t           ef;
         @(negedge clk);
         if (rst_n && tx === 1'b0) begin
            st      = cyc;
            ep      = epoch;
            aborted = 1'b0;
            bits    = '0;
            for (int i = 0; i < NBITS && !aborted; i++) begin
               while (cyc < st + i * CPB + 2 && epoch == ep) @(negedge clk);
               if (epoch != ep) aborted = 1'b1;
               else             bits[i] = tx;
            end
            if (!aborted) begin
               n_frames++;
               if (exp_frames.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL frame_unexpected: got byte %02h at cycle %0d, expected no frame", bits[8:1], st);
               end else begin
                  ef = exp_frames.pop_front();
                  check("frame_start_cycle", st, ef.start);
                  check("frame_start_bit", int'(bits[0]), 0);
                  check("frame_data", int'(bits[8:1]), int'(ef.dat));
`ifdef UART_TX_PARITY_EN
                  check("frame_parity", int'(bits[9]), int'(^ef.dat));
`endif
                  check("frame_stop_bit", int'(bits[NBITS-1]), 1);
               end
            end
         end
      end
   end

   task automatic step(input bit wen, input bit en, input logic [7:0] d);
      tx_wen  = wen;
      clk_en  = en;
      tx_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name, input int limit);
      int n = 0;
      while ((m_rem != 0 || m_q.size() != 0 || exp_frames.size() != 0) && n < limit) begin
         step(1'b0, 1'b0, 8'h00);
         n++;
      end
      check({name, "_drain_timeout"}, int'(n >= limit), 0);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) step(1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
   endtask

   initial begin : stim
      int         e;
      int         n;
      int         fr0;
      int         peak;
      bit         saw_full;
      logic [8:0] pat;

      // Reset values.
      do_reset(3);
      check("reset_tx", int'(tx), 1);

      // Single 0xA5: latency, line pattern, done interrupt, busy drop.
      step(1'b1, 1'b1, 8'hA5);
      check("latency_push_edge_tx", int'(tx), 1);
      step(1'b0, 1'b0, 8'h00);
      check("latency_start_tx", int'(tx), 0);
      e   = cyc;
      pat = {8'hA5, 1'b0};
      for (int k = 0; k < 9; k++) begin
         while (cyc < e + k * CPB + 2) step(1'b0, 1'b0, 8'h00);
         check("a5_line_sample", int'(tx), int'(pat[k]));
      end
      while (cyc < e + (NBITS - 1) * CPB + 2) step(1'b0, 1'b0, 8'h00);
      check("a5_stop_sample", int'(tx), 1);
      while (!tx_done_irq && cyc < e + FRAME + 20) step(1'b0, 1'b0, 8'h00);
      check("a5_irq_delay", cyc - e, FRAME);
      check("a5_busy_after_done", int'(tx_busy), 0);
      drain("a5", 100);

      // Held strobe, only one enabled cycle.
      fr0  = n_frames;
      peak = 0;
      step(1'b1, 1'b0, 8'h3C);
      step(1'b1, 1'b1, 8'h3C);
      if (fifo_count > peak) peak = fifo_count;
      step(1'b1, 1'b0, 8'h3C);
      if (fifo_count > peak) peak = fifo_count;
      step(1'b0, 1'b0, 8'h00);
      drain("held", 100);
      check("held_peak_count", peak, 1);
      check("held_frames", n_frames - fr0, 1);

      // Six back-to-back writes into a 4-deep FIFO.
      fr0      = n_frames;
      saw_full = 1'b0;
      for (int b = 1; b <= 6; b++) begin
         step(1'b1, 1'b1, 8'(b));
         if (fifo_full) saw_full = 1'b1;
      end
      step(1'b0, 1'b0, 8'h00);
      check("burst_overflow", int'(overflow), 1);
      check("burst_saw_full", int'(saw_full), 1);
      drain("burst", 400);
      check("burst_frames", n_frames - fr0, 5);
      check("burst_overflow_sticky", int'(overflow), 1);

      // Write while full on the very edge a stop bit ends and a pop happens.
      do_reset(2);
      for (int b = 0; b < 5; b++) step(1'b1, 1'b1, 8'h11 + 8'(b));
      check("sim_pre_overflow", int'(overflow), 0);
      n = 0;
      while (m_rem != 1 && n < 100) begin
         step(1'b0, 1'b0, 8'h00);
         n++;
      end
      check("sim_wait_timeout", int'(n >= 100), 0);
      step(1'b1, 1'b1, 8'h77);
      check("sim_overflow", int'(overflow), 1);
      check("sim_count_after_drop", int'(fifo_count), DEPTH - 1);
      drain("sim", 400);

      // Reset during data bit 3 of 0xFF with bytes still queued.
      step(1'b1, 1'b1, 8'hFF);
      step(1'b1, 1'b1, 8'h11);
      e = cyc;
      step(1'b1, 1'b1, 8'h22);
      while (cyc < e + CPB * 4 + 1) step(1'b0, 1'b0, 8'h00);
      check("midreset_pre_tx", int'(tx), 1);
      rst_n = 1'b0;
      step(1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      check("midreset_tx", int'(tx), 1);
      check("midreset_count", int'(fifo_count), 0);
      check("midreset_overflow", int'(overflow), 0);
      fr0 = n_frames;
      repeat (3 * FRAME) step(1'b0, 1'b0, 8'h00);
      check("midreset_no_frames", n_frames - fr0, 0);

      // Parity-sensitive bytes (odd and even weight).
      step(1'b1, 1'b1, 8'h07);
      drain("p07", 100);
      step(1'b1, 1'b1, 8'h03);
      drain("p03", 100);

      // Randomized traffic.
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 99) < 12, $urandom_range(0, 3) != 0, 8'($urandom));
      drain("random", 1000);
      check("leftover_frames", exp_frames.size(), 0);

      running = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
